// File: rtl/fpgaminer_pkg.sv
// Shared address map, CTRL/STATUS bit positions and the work item type for the work loader.
package fpgaminer_pkg;
  localparam logic [4:0] ADDR_DATA2_BASE    = 5'd0;
  localparam logic [4:0] ADDR_MIDSTATE_BASE = 5'd8;
  localparam logic [4:0] ADDR_CTRL          = 5'd16;
  localparam logic [4:0] ADDR_STATUS        = 5'd17;
  localparam logic [4:0] ADDR_NONCE         = 5'd18;
  localparam logic [4:0] ADDR_COUNT         = 5'd19;

  localparam int CTRL_LOAD       = 0;
  localparam int CTRL_CLR_STICKY = 1;

  localparam int STAT_WORK_VALID   = 0;
  localparam int STAT_FIFO_EMPTY   = 1;
  localparam int STAT_FIFO_FULL    = 2;
  localparam int STAT_LOAD_OVERRUN = 3;
  localparam int STAT_NONCE_OVF    = 4;

  typedef struct packed {
    logic [255:0] midstate;
    logic [255:0] data2;
  } work_t;
endpackage

// File: rtl/fpgaminer_work_loader_if.sv
// Avalon-MM slave, work handshake and golden-nonce strobe of the work loader.
interface fpgaminer_work_loader_if;
  logic [4:0]   avs_address;
  logic         avs_write;
  logic [31:0]  avs_writedata;
  logic         avs_read;
  logic [31:0]  avs_readdata;
  logic [255:0] work_midstate;
  logic [255:0] work_data2;
  logic         work_valid;
  logic         work_ready;
  logic         nonce_valid;
  logic [31:0]  nonce;

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read, work_ready, nonce_valid, nonce,
    output avs_readdata, work_midstate, work_data2, work_valid
  );
  modport master (
    output avs_address, avs_write, avs_writedata, avs_read, work_ready, nonce_valid, nonce,
    input  avs_readdata, work_midstate, work_data2, work_valid
  );
endinterface

// File: rtl/fpgaminer_nonce_fifo.sv
// Golden-nonce FIFO; a push while full is dropped unless a pop frees a slot in the same cycle.
module fpgaminer_nonce_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [31:0]   data_i,
  input  logic          pop_i,
  output logic [31:0]   head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fpgaminer_work_loader.sv
// Double-buffered work loader with golden-nonce FIFO behind an Avalon-MM slave.
// Define FPGAMINER_WORK_AUTOLOAD_EN to commit automatically on a write to the last midstate word.
module fpgaminer_work_loader
  import fpgaminer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  fpgaminer_work_loader_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0][31:0] shadow_q, shadow_d;
  work_t             work_q, work_d;
  logic              work_valid_q, work_valid_d;
  logic              ovr_q, ovr_d, novf_q, novf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ctrl_wr, load, clr, commit, accept;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [31:0]       fifo_head;
  logic [CW-1:0]     fifo_count;

  always_comb begin
    shadow_d = shadow_q;
    if (bus.avs_write && !bus.avs_address[4]) shadow_d[bus.avs_address[3:0]] = bus.avs_writedata;
  end

  assign ctrl_wr = bus.avs_write && (bus.avs_address == ADDR_CTRL);
  assign load    = ctrl_wr && bus.avs_writedata[CTRL_LOAD];
  assign clr     = ctrl_wr && bus.avs_writedata[CTRL_CLR_STICKY];
`ifdef FPGAMINER_WORK_AUTOLOAD_EN
  assign commit  = load || (bus.avs_write && (bus.avs_address == ADDR_MIDSTATE_BASE + 5'd7));
`else
  assign commit  = load;
`endif
  assign accept  = work_valid_q && bus.work_ready;

  // Commit from shadow_d: a CTRL write never touches the shadow, and an autoload sees word 15 updated.
  assign work_d.data2    = shadow_d[7:0];
  assign work_d.midstate = shadow_d[15:8];
  assign work_valid_d    = commit ? 1'b1 : (accept ? 1'b0 : work_valid_q);

  // Set beats clear so an event coinciding with CLR_STICKY is not lost.
  assign ovr_d    = (ovr_q && !clr) || (commit && work_valid_q && !accept);
  assign novf_d   = (novf_q && !clr) || (bus.nonce_valid && fifo_full && !fifo_pop);
  assign fifo_pop = bus.avs_read && (bus.avs_address == ADDR_NONCE) && !fifo_empty;

  always_comb begin
    rdata_d = '0;
    if (!bus.avs_address[4]) rdata_d = shadow_q[bus.avs_address[3:0]];
    else begin
      case (bus.avs_address)
        ADDR_STATUS: begin
          rdata_d[STAT_WORK_VALID]   = work_valid_q;
          rdata_d[STAT_FIFO_EMPTY]   = fifo_empty;
          rdata_d[STAT_FIFO_FULL]    = fifo_full;
          rdata_d[STAT_LOAD_OVERRUN] = ovr_q;
          rdata_d[STAT_NONCE_OVF]    = novf_q;
        end
        ADDR_NONCE: rdata_d = fifo_empty ? 32'd0 : fifo_head;
        ADDR_COUNT: rdata_d = 32'(fifo_count);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q     <= '0;
      work_q       <= '0;
      work_valid_q <= 1'b0;
      ovr_q        <= 1'b0;
      novf_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      shadow_q     <= shadow_d;
      if (commit) work_q <= work_d;
      work_valid_q <= work_valid_d;
      ovr_q        <= ovr_d;
      novf_q       <= novf_d;
      if (bus.avs_read) rdata_q <= rdata_d;
    end
  end

  fpgaminer_nonce_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (bus.nonce_valid),
    .data_i  (bus.nonce),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.avs_readdata  = rdata_q;
  assign bus.work_midstate = work_q.midstate;
  assign bus.work_data2    = work_q.data2;
  assign bus.work_valid    = work_valid_q;
endmodule

// File: tb/tb_fpgaminer_work_loader.sv
// Self-checking bench for fpgaminer_work_loader: readback scoreboard plus a reference nonce queue.
module tb_fpgaminer_work_loader;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fpgaminer_work_loader_if bus ();
  fpgaminer_work_loader #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] mq[$];
  logic        m_ovf = 1'b0;
  logic [31:0] got, exp_v;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic ready_pulse();
    @(negedge clk); bus.work_ready = 1'b1;
    @(negedge clk); bus.work_ready = 1'b0;
  endtask

  task automatic push_nonce(input logic [31:0] v);
    @(negedge clk);
    bus.nonce = v; bus.nonce_valid = 1'b1;
    if (mq.size() < DEPTH) mq.push_back(v); else m_ovf = 1'b1;
    @(negedge clk);
    bus.nonce_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.avs_address = '0; bus.avs_write = 0; bus.avs_writedata = '0; bus.avs_read = 0;
    bus.work_ready = 0; bus.nonce_valid = 0; bus.nonce = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.work_valid !== 1'b0 || bus.work_data2 !== '0 || bus.work_midstate !== '0 || bus.avs_readdata !== '0) begin
      n_err++; $display("FAIL reset_outputs: valid=%b d2=%h ms=%h rd=%h, want all 0",
                        bus.work_valid, bus.work_data2[31:0], bus.work_midstate[31:0], bus.avs_readdata);
    end
    sb.push_back(32'h02); bus_read(5'd17, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL reset_status: got %h want %h", got, exp_v); end
    sb.push_back(32'h0); bus_read(5'd19, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL reset_count: got %h want %h", got, exp_v); end
  endtask

  task automatic test_load();
    logic [3:0] n;
    for (int i = 0; i < 16; i++) begin
      n = 4'(i);
      bus_write(5'(i), {8{n}});
    end
`ifdef FPGAMINER_WORK_AUTOLOAD_EN
    n_cmp++; if (bus.work_valid !== 1'b1) begin n_err++; $display("FAIL autoload_w15: valid=%b want 1", bus.work_valid); end
`else
    n_cmp++; if (bus.work_valid !== 1'b0) begin n_err++; $display("FAIL preload_valid: valid=%b want 0", bus.work_valid); end
`endif
    bus_write(5'd16, 32'h1);
    n_cmp++;
    if (bus.work_valid !== 1'b1 || bus.work_data2[31:0] !== 32'h0 || bus.work_midstate[255:224] !== 32'hFFFFFFFF
        || bus.work_data2[255:224] !== 32'h77777777 || bus.work_midstate[31:0] !== 32'h88888888) begin
      n_err++; $display("FAIL load_commit: valid=%b d2_0=%h d2_7=%h ms_8=%h ms_15=%h", bus.work_valid,
                        bus.work_data2[31:0], bus.work_data2[255:224], bus.work_midstate[31:0], bus.work_midstate[255:224]);
    end
    bus_write(5'd0, 32'hDEAD0000);
    bus_write(5'd20, 32'hFFFFFFFF);
    sb.push_back(32'hDEAD0000); bus_read(5'd0, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL shadow_read: got %h want %h", got, exp_v); end
    n_cmp++; if (bus.work_data2[31:0] !== 32'h0) begin n_err++; $display("FAIL active_hold: got %h want 0", bus.work_data2[31:0]); end
    sb.push_back(32'hCCCCCCCC); bus_read(5'd12, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL shadow_w12: got %h want %h", got, exp_v); end
    sb.push_back(32'h0); bus_read(5'd20, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL unmapped: got %h want %h", got, exp_v); end
    ready_pulse();
    n_cmp++; if (bus.work_valid !== 1'b0) begin n_err++; $display("FAIL accept: valid=%b want 0", bus.work_valid); end
    bus_write(5'd16, 32'h2);
  endtask

  task automatic test_overrun();
    bus_write(5'd16, 32'h1);
    bus_write(5'd16, 32'h1);
    sb.push_back(32'h0B); bus_read(5'd17, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL overrun_status: got %h want %h", got, exp_v); end
    ready_pulse();
    n_cmp++; if (bus.work_valid !== 1'b0) begin n_err++; $display("FAIL overrun_accept: valid=%b want 0", bus.work_valid); end
    bus_write(5'd16, 32'h2);
    sb.push_back(32'h02); bus_read(5'd17, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL clr_status: got %h want %h", got, exp_v); end
    // LOAD together with an accept: stays valid, no overrun
    bus_write(5'd16, 32'h1);
    @(negedge clk);
    bus.avs_address = 5'd16; bus.avs_writedata = 32'h1; bus.avs_write = 1'b1; bus.work_ready = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0; bus.work_ready = 1'b0;
    sb.push_back(32'h03); bus_read(5'd17, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL load_accept: got %h want %h", got, exp_v); end
    // LOAD+CLR while valid: the new overrun wins over the clear
    bus_write(5'd16, 32'h3);
    sb.push_back(32'h0B); bus_read(5'd17, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL sticky_wins: got %h want %h", got, exp_v); end
    bus_write(5'd16, 32'h2);
    ready_pulse();
  endtask

  task automatic test_fifo();
    for (int i = 0; i < 9; i++) push_nonce(32'hA0 + 32'(i));
    sb.push_back(32'(mq.size())); bus_read(5'd19, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL fifo_count: got %h want %h", got, exp_v); end
    sb.push_back({27'd0, m_ovf, 1'b0, 1'b1, 1'b0, 1'b0}); bus_read(5'd17, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL fifo_ovf_status: got %h want %h", got, exp_v); end
    for (int i = 0; i < 9; i++) begin
      sb.push_back(mq.size() != 0 ? mq.pop_front() : 32'h0);
      bus_read(5'd18, got); exp_v = sb.pop_front();
      n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL fifo_pop%0d: got %h want %h", i, got, exp_v); end
    end
    sb.push_back(32'h0); bus_read(5'd19, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL fifo_drained: got %h want %h", got, exp_v); end
    bus_write(5'd16, 32'h2);
    m_ovf = 1'b0;
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 8; i++) push_nonce(32'hB0 + 32'(i));
    @(negedge clk);
    bus.avs_address = 5'd18; bus.avs_read = 1'b1; bus.nonce = 32'hB8; bus.nonce_valid = 1'b1;
    sb.push_back(mq.pop_front()); mq.push_back(32'hB8);
    @(negedge clk);
    bus.avs_read = 1'b0; bus.nonce_valid = 1'b0;
    got = bus.avs_readdata; exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL full_pop_head: got %h want %h", got, exp_v); end
    sb.push_back(32'h04); bus_read(5'd17, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL full_pop_status: got %h want %h", got, exp_v); end
    while (mq.size() != 0) begin
      sb.push_back(mq.pop_front()); bus_read(5'd18, got); exp_v = sb.pop_front();
      n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL full_pop_order: got %h want %h", got, exp_v); end
    end
    // empty FIFO: push and NONCE read in one cycle returns 0 and keeps the push
    @(negedge clk);
    bus.avs_address = 5'd18; bus.avs_read = 1'b1; bus.nonce = 32'hC0; bus.nonce_valid = 1'b1;
    sb.push_back(32'h0); mq.push_back(32'hC0);
    @(negedge clk);
    bus.avs_read = 1'b0; bus.nonce_valid = 1'b0;
    got = bus.avs_readdata; exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL empty_push_read: got %h want %h", got, exp_v); end
    sb.push_back(mq.pop_front()); bus_read(5'd18, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL empty_push_kept: got %h want %h", got, exp_v); end
  endtask

  task automatic test_autoload();
    bus_write(5'd15, 32'h12345678);
`ifdef FPGAMINER_WORK_AUTOLOAD_EN
    n_cmp++;
    if (bus.work_valid !== 1'b1 || bus.work_midstate[255:224] !== 32'h12345678) begin
      n_err++; $display("FAIL autoload: valid=%b ms15=%h want 1/12345678", bus.work_valid, bus.work_midstate[255:224]);
    end
    ready_pulse();
`else
    n_cmp++;
    if (bus.work_valid !== 1'b0 || bus.work_midstate[255:224] !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL no_autoload: valid=%b ms15=%h want 0/ffffffff", bus.work_valid, bus.work_midstate[255:224]);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bus_write(5'd16, 32'h1);
    push_nonce(32'hE0);
    push_nonce(32'hE1);
    bus_read(5'd17, got);
    @(negedge clk);
    bus.avs_address = 5'd3; bus.avs_writedata = 32'h99; bus.avs_write = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.work_valid !== 1'b0 || bus.work_data2 !== '0 || bus.work_midstate !== '0 || bus.avs_readdata !== '0) begin
      n_err++; $display("FAIL midreset_outputs: valid=%b d2=%h ms=%h rd=%h, want all 0",
                        bus.work_valid, bus.work_data2[31:0], bus.work_midstate[255:224], bus.avs_readdata);
    end
    bus.avs_write = 1'b0;
    mq.delete(); m_ovf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.push_back(32'h0); bus_read(5'd19, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL midreset_count: got %h want %h", got, exp_v); end
    sb.push_back(32'h0); bus_read(5'd3, got); exp_v = sb.pop_front();
    n_cmp++; if (got !== exp_v) begin n_err++; $display("FAIL midreset_shadow: got %h want %h", got, exp_v); end
    bus_write(5'd0, 32'h55);
    bus_write(5'd16, 32'h1);
    n_cmp++;
    if (bus.work_valid !== 1'b1 || bus.work_data2[31:0] !== 32'h55) begin
      n_err++; $display("FAIL post_reset_load: valid=%b d2_0=%h want 1/55", bus.work_valid, bus.work_data2[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_overrun();
    test_fifo();
    test_full_pop();
    test_autoload();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
